// File: rtl/ce_prescaler_pkg.sv
// Shared definitions for the clock-enable prescaler: FSM state encodings and
// default widths.
package ce_prescaler_pkg;

  localparam int DIV_W_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    ST_STOP    = 2'b00,
    ST_RUN     = 2'b01,
    ST_STEP    = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_e;

endpackage

// File: rtl/ce_prescaler_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pad input, followed by a
// rising-edge detector on the synchronised level.
module ce_prescaler_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic n_reset_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_i};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_reg[SYNC_STAGES-1];
  assign rise_o  = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/ce_prescaler.sv
// Programmable clock-enable generator: free-running pulse every div+1 cycles
// while run is asserted, or exactly one pulse per step request.
module ce_prescaler
  import ce_prescaler_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk_i,
  input  logic             n_reset_i,
  input  logic             run_i,
  input  logic             step_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             ce_o,
  output logic             running_o
);

  logic run_s;
  logic run_rise_unused;
  logic step_s;
  logic step_rise;

  state_e           state_reg, state_next;
  logic [DIV_W-1:0] presc_reg, presc_next;
  logic [DIV_W-1:0] div_q_reg, div_q_next;
  logic             ce_reg, ce_next;

  ce_prescaler_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_run (
    .clk_i     (clk_i),
    .n_reset_i (n_reset_i),
    .async_i   (run_i),
    .level_o   (run_s),
    .rise_o    (run_rise_unused)
  );

  ce_prescaler_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_step (
    .clk_i     (clk_i),
    .n_reset_i (n_reset_i),
    .async_i   (step_i),
    .level_o   (step_s),
    .rise_o    (step_rise)
  );

  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      state_reg <= ST_STOP;
      presc_reg <= '0;
      div_q_reg <= '0;
      ce_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
      div_q_reg <= div_q_next;
      ce_reg    <= ce_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    presc_next = presc_reg;
    div_q_next = div_q_reg;
    ce_next    = 1'b0;
    case (state_reg)
      ST_STOP: begin
        presc_next = '0;
        if (run_s) begin
          state_next = ST_RUN;
          div_q_next = div_i;
        end else if (step_rise) begin
          state_next = ST_STEP;
          div_q_next = div_i;
        end
      end
      ST_RUN: begin
        if (!run_s) begin
          // Partial period is discarded; restart always counts a full period.
          state_next = ST_STOP;
          presc_next = '0;
        end else if (presc_reg == div_q_reg) begin
          ce_next    = 1'b1;
          presc_next = '0;
        end else begin
          presc_next = presc_reg + DIV_W'(1);
        end
      end
      ST_STEP: begin
        if (presc_reg == div_q_reg) begin
          ce_next    = 1'b1;
          presc_next = '0;
          state_next = run_s ? ST_RUN : ST_STOP;
        end else begin
          presc_next = presc_reg + DIV_W'(1);
          // Promoting to RUN keeps the count so the pending pulse is not lost.
          if (run_s) state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_STOP;
        presc_next = '0;
      end
    endcase
  end

  assign ce_o      = ce_reg;
  assign running_o = (state_reg != ST_STOP);

`ifdef FORMAL
  always_ff @(posedge clk_i) begin
    if (n_reset_i) begin
      assert (presc_reg <= div_q_reg);
      // A step pulse always leaves STEP, so ce never shows while still in STEP.
      assert (!(state_reg == ST_STEP && ce_reg));
      assert (!(state_reg == ST_STOP && ce_reg && $past(state_reg) != ST_STEP));
    end
  end
`endif

endmodule

// File: tb/tb_ce_prescaler.sv
// Randomised and directed bench for ce_prescaler against a countdown model.
module tb_ce_prescaler;

  localparam int DIV_W = 8;
  localparam int S     = 2;

  logic             clk_i     = 1'b0;
  logic             n_reset_i = 1'b0;
  logic             run_i     = 1'b0;
  logic             step_i    = 1'b0;
  logic [DIV_W-1:0] div_i     = '0;
  logic             ce_o;
  logic             running_o;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk_i = ~clk_i;

  ce_prescaler #(.DIV_W(DIV_W), .SYNC_STAGES(S)) dut (
    .clk_i     (clk_i),
    .n_reset_i (n_reset_i),
    .run_i     (run_i),
    .step_i    (step_i),
    .div_i     (div_i),
    .ce_o      (ce_o),
    .running_o (running_o)
  );

  // Model: mode 0 idle, 1 free-running, 2 single pulse; m_cnt counts down
  // edges to the next pulse. rh/sh hold input samples taken 1..S+1 edges ago.
  int m_mode = 0;
  int m_cnt  = 0;
  int m_div  = 0;
  bit m_ce   = 1'b0;
  bit rh [0:S];
  bit sh [0:S];

  task automatic model_reset();
    m_mode = 0;
    m_ce   = 1'b0;
    for (int j = 0; j <= S; j++) begin
      rh[j] = 1'b0;
      sh[j] = 1'b0;
    end
  endtask

  always @(negedge n_reset_i) model_reset();

  always @(posedge clk_i) begin : model
    bit rs, rise;
    if (!n_reset_i) begin
      model_reset();
    end else begin
      rs   = rh[S-1];
      rise = sh[S-1] && !sh[S];
      m_ce = 1'b0;
      case (m_mode)
        0: begin
          if (rs || rise) begin
            m_mode = rs ? 1 : 2;
            m_div  = int'(div_i);
            m_cnt  = m_div + 1;
          end
        end
        1: begin
          if (!rs) m_mode = 0;
          else begin
            m_cnt--;
            if (m_cnt == 0) begin
              m_ce  = 1'b1;
              m_cnt = m_div + 1;
            end
          end
        end
        default: begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_ce   = 1'b1;
            m_cnt  = m_div + 1;
            m_mode = rs ? 1 : 0;
          end else if (rs) begin
            m_mode = 1;
          end
        end
      endcase
      for (int j = S; j > 0; j--) begin
        rh[j] = rh[j-1];
        sh[j] = sh[j-1];
      end
      rh[0] = run_i;
      sh[0] = step_i;
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      n_cmp++;
      if (ce_o !== m_ce || running_o !== (m_mode != 0)) begin
        n_err++;
        $display("FAIL model t=%0t ce_o=%b exp %b running_o=%b exp %b",
                 $time, ce_o, m_ce, running_o, (m_mode != 0));
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("check %s: %0d", name, act);
    end
  endtask

  // Counts falling edges until ce_o is seen at the given level.
  task automatic wait_level(input logic lvl, input int max, output int n);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (ce_o !== lvl && n < max);
    if (ce_o !== lvl) begin
      n_err++;
      $display("FAIL timeout waiting ce_o=%b after %0d cycles", lvl, n);
    end
  endtask

  task automatic count_pulses(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk_i);
      if (ce_o) cnt++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, r;
    repeat (3) @(negedge clk_i);
    chk_en = 1'b1;
    check("reset_ce", ce_o, 0);
    check("reset_running", running_o, 0);
    @(negedge clk_i);
    n_reset_i = 1'b1;

    // Free run, div 3
    div_i = 3; run_i = 1'b1;
    wait_level(1'b1, 50, n);  check("t1_first", n, 7);
    wait_level(1'b1, 50, n);  check("t1_period", n, 4);
    count_pulses(516, cnt);   check("t1_129_pulses", cnt, 129);
    run_i = 1'b0;
    repeat (10) @(negedge clk_i);

    // div 0: continuous enable, then stop
    div_i = 0; run_i = 1'b1;
    repeat (10) @(negedge clk_i);
    check("t2_ce_high", ce_o, 1);
    run_i = 1'b0;
    wait_level(1'b0, 20, n);  check("t2_drop", n, 3);
    check("t2_running", running_o, 0);
    repeat (5) @(negedge clk_i);

    // Single steps, div 5
    div_i = 5;
    for (int k = 0; k < 3; k++) begin
      step_i = 1'b1;
      wait_level(1'b1, 40, n); check("t3_step", n, 9);
      step_i = 1'b0;
      count_pulses(20, cnt);   check("t3_no_extra", cnt, 0);
    end

    // Step promoted to run mid-count, div 7
    div_i = 7; step_i = 1'b1;
    repeat (3) @(negedge clk_i);
    run_i = 1'b1;
    wait_level(1'b1, 40, n);  check("t4_first", n, 8);
    wait_level(1'b1, 40, n);  check("t4_period", n, 8);
    check("t4_running", running_o, 1);
    step_i = 1'b0; run_i = 1'b0;
    repeat (10) @(negedge clk_i);

    // div change while running is ignored until restart
    div_i = 4; run_i = 1'b1;
    wait_level(1'b1, 40, n);
    wait_level(1'b1, 40, n);  check("t5_period5", n, 5);
    div_i = 9;
    wait_level(1'b1, 40, n);
    wait_level(1'b1, 40, n);  check("t5_still5", n, 5);
    run_i = 1'b0;
    repeat (8) @(negedge clk_i);
    run_i = 1'b1;
    wait_level(1'b1, 40, n);  check("t5_restart_first", n, 13);
    wait_level(1'b1, 40, n);  check("t5_period10", n, 10);
    run_i = 1'b0;
    repeat (8) @(negedge clk_i);

    // Maximum divider: period 2^DIV_W
    div_i = 8'hFF; run_i = 1'b1;
    wait_level(1'b1, 400, n); check("tmax_first", n, 259);
    wait_level(1'b1, 400, n); check("tmax_period", n, 256);
    run_i = 1'b0;
    repeat (8) @(negedge clk_i);

    // Reset in the middle of running
    div_i = 0; run_i = 1'b1;
    repeat (8) @(negedge clk_i);
    check("t6_ce_before", ce_o, 1);
    @(negedge clk_i);
    #2 n_reset_i = 1'b0;
    #1;
    check("t6_ce_reset", ce_o, 0);
    check("t6_running_reset", running_o, 0);
    repeat (2) @(negedge clk_i);
    div_i = 3;
    n_reset_i = 1'b1;
    wait_level(1'b1, 50, n);  check("t6_restart_first", n, 7);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      r = $urandom_range(0, 99);
      if (r < 3) run_i = ~run_i;
      else if (r < 10) step_i = ~step_i;
      if ($urandom_range(0, 19) == 0)
        div_i = ($urandom_range(0, 9) == 0) ? 8'hFF : DIV_W'($urandom_range(0, 7));
      if ($urandom_range(0, 499) == 0) begin
        #2 n_reset_i = 1'b0;
        @(negedge clk_i);
        n_reset_i = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
